layer_norm_in_streamer: RTL and testbench

Upstream feeder for the layer-norm vector engine. On a start pulse it reads one token vector of int8 activations from the activation SRAM. It also reads the matching packed gamma/beta words from the parameter SRAM. It then issues the one-cycle config pulses (data_num, in/out scale position) and streams BUS_NUM-lane words with per-lane valid masks, tail lanes masked. It stays busy until layer-norm reports `ln_last`, so one vector is in flight at a time.

---
 rtl/ln_pkg.sv | 36 +++
 rtl/ln_tail_mask.sv | 31 +++
 rtl/layer_norm_in_streamer.sv | 210 +++++++++++++++++++++
 tb/tb_layer_norm_in_streamer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ln_pkg.sv
// ---------------------------------------------------------------------------
// ln_pkg
// Shared definitions for the layer-norm input streamer:
//   - ln_state_e    : streamer FSM state encoding
//   - LN_FP_WIDTH   : bf16 gamma/beta element width
//   - LN_MAX_LANES  : widest lane count the mask helper supports
//   - mask_from_rem : lane mask for a partially filled final word
// ---------------------------------------------------------------------------
package ln_pkg;

    typedef enum logic [2:0] {
        LN_IDLE,
        LN_CFG,
        LN_READ,
        LN_DRAIN,
        LN_WAIT_LN,
        LN_DONE
    } ln_state_e;

    localparam int LN_FP_WIDTH  = 16;
    localparam int LN_MAX_LANES = 64;

    // A remainder of zero means the final word is completely full, so every
    // lane is valid; otherwise only the low 'rem' lanes carry elements.
    // Callers truncate the result to their own lane count.
    function automatic logic [LN_MAX_LANES-1:0] mask_from_rem(input int rem);
        logic [LN_MAX_LANES-1:0] m;
        if (rem == 0) begin
            m = '1;
        end else begin
            m = ~({LN_MAX_LANES{1'b1}} << rem);
        end
        return m;
    endfunction

endpackage

// File: rtl/ln_tail_mask.sv
// ---------------------------------------------------------------------------
// ln_tail_mask
// Combinational lane-mask generator for the word currently being read.
// Ports:
//   word_idx : index of the word being issued (0 .. word_cnt-1)
//   word_cnt : total number of words in the vector
//   rem      : data_num mod BUS_NUM
//   mask     : per-lane valid mask for word_idx
// ---------------------------------------------------------------------------
module ln_tail_mask
    import ln_pkg::*;
#(
    parameter int BUS_NUM        = 8,
    parameter int DATA_NUM_WIDTH = 10,
    parameter int LANE_W         = $clog2(BUS_NUM)
) (
    input  logic [DATA_NUM_WIDTH-1:0] word_idx,
    input  logic [DATA_NUM_WIDTH-1:0] word_cnt,
    input  logic [LANE_W-1:0]         rem,
    output logic [BUS_NUM-1:0]        mask
);

    // Only the final word of a vector can be partial; every earlier word is full.
    always_comb begin
        mask = '1;
        if (word_idx == (word_cnt - DATA_NUM_WIDTH'(1))) begin
            mask = BUS_NUM'(mask_from_rem(int'(rem)));
        end
    end

endmodule

// File: rtl/layer_norm_in_streamer.sv
// ---------------------------------------------------------------------------
// layer_norm_in_streamer
// Feeds one token vector of int8 activations plus matching bf16 gamma/beta
// words into the layer-norm engine. On start it latches the config, emits
// the three config pulses, reads ceil(data_num/BUS_NUM) words from both
// SRAMs and streams them out with per-lane valid masks, then stays busy
// until the engine reports ln_last.
//
// Optional feature macro: LN_STREAM_LANE_ZERO_EN
//   defined   : invalid lanes of data/gamma/beta are driven to zero
//   undefined : raw SRAM contents appear on invalid lanes
//
// Ports:
//   clk, rst_n (async, active-low)
//   start + cfg_* : launch and vector configuration
//   act_rd_* / par_rd_* : activation / parameter SRAM read ports (1-cycle latency)
//   ln_* : config pulses and data stream to layer-norm, ln_last back from it
//   busy, done : status
// ---------------------------------------------------------------------------
module layer_norm_in_streamer
    import ln_pkg::*;
#(
    parameter int BUS_NUM         = 8,
    parameter int DATA_NUM_WIDTH  = 10,
    parameter int SCALA_POS_WIDTH = 5,
    parameter int ADDR_WIDTH      = 8,
    parameter int FP_WIDTH        = LN_FP_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [DATA_NUM_WIDTH-1:0]         cfg_data_num,
    input  logic [ADDR_WIDTH-1:0]             cfg_act_base,
    input  logic [ADDR_WIDTH-1:0]             cfg_par_base,
    input  logic signed [SCALA_POS_WIDTH-1:0] cfg_in_scale_pos,
    input  logic signed [SCALA_POS_WIDTH-1:0] cfg_out_scale_pos,
    output logic                              act_rd_en,
    output logic [ADDR_WIDTH-1:0]             act_rd_addr,
    input  logic [BUS_NUM*8-1:0]              act_rd_data,
    output logic                              par_rd_en,
    output logic [ADDR_WIDTH-1:0]             par_rd_addr,
    input  logic [2*BUS_NUM*FP_WIDTH-1:0]     par_rd_data,
    output logic [DATA_NUM_WIDTH-1:0]         ln_data_num,
    output logic                              ln_data_num_vld,
    output logic signed [SCALA_POS_WIDTH-1:0] ln_in_scale_pos,
    output logic                              ln_in_scale_pos_vld,
    output logic signed [SCALA_POS_WIDTH-1:0] ln_out_scale_pos,
    output logic                              ln_out_scale_pos_vld,
    output logic [BUS_NUM*8-1:0]              ln_fixed_data,
    output logic [BUS_NUM-1:0]                ln_fixed_data_vld,
    output logic [BUS_NUM*FP_WIDTH-1:0]       ln_gamma,
    output logic [BUS_NUM-1:0]                ln_gamma_vld,
    output logic [BUS_NUM*FP_WIDTH-1:0]       ln_beta,
    output logic [BUS_NUM-1:0]                ln_beta_vld,
    input  logic                              ln_last,
    output logic                              busy,
    output logic                              done
);

    localparam int LANE_W = $clog2(BUS_NUM);
    localparam int HALF_W = BUS_NUM * FP_WIDTH;

    ln_state_e                 state;
    ln_state_e                 next_state;
    logic [DATA_NUM_WIDTH-1:0] word_cnt;
    logic [DATA_NUM_WIDTH-1:0] rd_idx;
    logic [DATA_NUM_WIDTH-1:0] start_word_cnt;
    logic [LANE_W-1:0]         rem;
    logic [BUS_NUM-1:0]        lane_mask;
    logic [BUS_NUM-1:0]        vld_p1;
    logic [BUS_NUM*8-1:0]      data_next;
    logic [HALF_W-1:0]         gamma_next;
    logic [HALF_W-1:0]         beta_next;

    // Word count: whole words plus one more if any remainder bit is set.
    assign start_word_cnt = (cfg_data_num >> LANE_W)
                          + DATA_NUM_WIDTH'(|cfg_data_num[LANE_W-1:0]);

    ln_tail_mask #(
        .BUS_NUM        (BUS_NUM),
        .DATA_NUM_WIDTH (DATA_NUM_WIDTH),
        .LANE_W         (LANE_W)
    ) u_tail_mask (
        .word_idx (rd_idx),
        .word_cnt (word_cnt),
        .rem      (rem),
        .mask     (lane_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LN_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ln_last is only honoured once the last data word has left the output
    // register, so an early end-of-vector pulse cannot cut the stream short.
    always_comb begin
        next_state = state;
        unique case (state)
            LN_IDLE: begin
                if (start) begin
                    next_state = (cfg_data_num == '0) ? LN_DONE : LN_CFG;
                end
            end
            LN_CFG:   next_state = LN_READ;
            LN_READ: begin
                if (rd_idx == (word_cnt - DATA_NUM_WIDTH'(1))) begin
                    next_state = LN_DRAIN;
                end
            end
            LN_DRAIN: next_state = LN_WAIT_LN;
            LN_WAIT_LN: begin
                if (ln_last && (ln_fixed_data_vld == '0)) begin
                    next_state = LN_DONE;
                end
            end
            LN_DONE:  next_state = LN_IDLE;
            default:  next_state = LN_IDLE;
        endcase
    end

    // Split the returning SRAM words into lanes, optionally blanking the
    // lanes that carry no element of this vector.
    always_comb begin
        data_next  = act_rd_data;
        gamma_next = par_rd_data[HALF_W-1:0];
        beta_next  = par_rd_data[2*HALF_W-1:HALF_W];
`ifdef LN_STREAM_LANE_ZERO_EN
        for (int i = 0; i < BUS_NUM; i++) begin
            if (!vld_p1[i]) begin
                data_next[8*i +: 8]               = '0;
                gamma_next[FP_WIDTH*i +: FP_WIDTH] = '0;
                beta_next[FP_WIDTH*i +: FP_WIDTH]  = '0;
            end
        end
`endif
    end

    // All outputs are registered from next_state so that every pulse lines
    // up with the state it belongs to. vld_p1 carries the lane mask of each
    // issued read for one cycle, matching the SRAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt             <= '0;
            rem                  <= '0;
            rd_idx               <= '0;
            vld_p1               <= '0;
            act_rd_en            <= 1'b0;
            act_rd_addr          <= '0;
            par_rd_en            <= 1'b0;
            par_rd_addr          <= '0;
            ln_data_num          <= '0;
            ln_data_num_vld      <= 1'b0;
            ln_in_scale_pos      <= '0;
            ln_in_scale_pos_vld  <= 1'b0;
            ln_out_scale_pos     <= '0;
            ln_out_scale_pos_vld <= 1'b0;
            ln_fixed_data        <= '0;
            ln_fixed_data_vld    <= '0;
            ln_gamma             <= '0;
            ln_gamma_vld         <= '0;
            ln_beta              <= '0;
            ln_beta_vld          <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
        end else begin
            ln_data_num_vld      <= 1'b0;
            ln_in_scale_pos_vld  <= 1'b0;
            ln_out_scale_pos_vld <= 1'b0;
            busy                 <= (next_state != LN_IDLE);
            done                 <= (next_state == LN_DONE);
            act_rd_en            <= (next_state == LN_READ);
            par_rd_en            <= (next_state == LN_READ);

            if ((state == LN_IDLE) && start) begin
                word_cnt    <= start_word_cnt;
                rem         <= cfg_data_num[LANE_W-1:0];
                rd_idx      <= '0;
                act_rd_addr <= cfg_act_base;
                par_rd_addr <= cfg_par_base;
                if (cfg_data_num != '0) begin
                    ln_data_num          <= cfg_data_num;
                    ln_in_scale_pos      <= cfg_in_scale_pos;
                    ln_out_scale_pos     <= cfg_out_scale_pos;
                    ln_data_num_vld      <= 1'b1;
                    ln_in_scale_pos_vld  <= 1'b1;
                    ln_out_scale_pos_vld <= 1'b1;
                end
            end else if ((state == LN_READ) && (next_state == LN_READ)) begin
                rd_idx      <= rd_idx + DATA_NUM_WIDTH'(1);
                act_rd_addr <= act_rd_addr + ADDR_WIDTH'(1);
                par_rd_addr <= par_rd_addr + ADDR_WIDTH'(1);
            end

            vld_p1            <= act_rd_en ? lane_mask : '0;
            ln_fixed_data_vld <= vld_p1;
            ln_gamma_vld      <= vld_p1;
            ln_beta_vld       <= vld_p1;
            if (vld_p1 != '0) begin
                ln_fixed_data <= data_next;
                ln_gamma      <= gamma_next;
                ln_beta       <= beta_next;
            end
        end
    end

endmodule

// File: tb/tb_layer_norm_in_streamer.sv
// ---------------------------------------------------------------------------
// tb_layer_norm_in_streamer
// Self-checking bench for layer_norm_in_streamer with BUS_NUM=8. Random
// SRAM contents and random vectors are compared cycle by cycle against a
// reference derived from element count, base addresses and fixed latencies.
// Honours LN_STREAM_LANE_ZERO_EN when computing expected lane contents.
// ---------------------------------------------------------------------------
module tb_layer_norm_in_streamer;

    localparam int BUS  = 8;
    localparam int DNW  = 10;
    localparam int SPW  = 5;
    localparam int AW   = 8;
    localparam int FPW  = 16;
    localparam int HALF = BUS * FPW;
`ifdef LN_STREAM_LANE_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [DNW-1:0]        cfg_data_num;
    logic [AW-1:0]         cfg_act_base;
    logic [AW-1:0]         cfg_par_base;
    logic signed [SPW-1:0] cfg_in_scale_pos;
    logic signed [SPW-1:0] cfg_out_scale_pos;
    logic                  act_rd_en;
    logic [AW-1:0]         act_rd_addr;
    logic [BUS*8-1:0]      act_rd_data;
    logic                  par_rd_en;
    logic [AW-1:0]         par_rd_addr;
    logic [2*HALF-1:0]     par_rd_data;
    logic [DNW-1:0]        ln_data_num;
    logic                  ln_data_num_vld;
    logic signed [SPW-1:0] ln_in_scale_pos;
    logic                  ln_in_scale_pos_vld;
    logic signed [SPW-1:0] ln_out_scale_pos;
    logic                  ln_out_scale_pos_vld;
    logic [BUS*8-1:0]      ln_fixed_data;
    logic [BUS-1:0]        ln_fixed_data_vld;
    logic [HALF-1:0]       ln_gamma;
    logic [BUS-1:0]        ln_gamma_vld;
    logic [HALF-1:0]       ln_beta;
    logic [BUS-1:0]        ln_beta_vld;
    logic                  ln_last;
    logic                  busy;
    logic                  done;

    logic [BUS*8-1:0]  act_mem [256];
    logic [2*HALF-1:0] par_mem [256];

    int total = 0;
    int bad   = 0;

    layer_norm_in_streamer #(
        .BUS_NUM         (BUS),
        .DATA_NUM_WIDTH  (DNW),
        .SCALA_POS_WIDTH (SPW),
        .ADDR_WIDTH      (AW),
        .FP_WIDTH        (FPW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .cfg_data_num         (cfg_data_num),
        .cfg_act_base         (cfg_act_base),
        .cfg_par_base         (cfg_par_base),
        .cfg_in_scale_pos     (cfg_in_scale_pos),
        .cfg_out_scale_pos    (cfg_out_scale_pos),
        .act_rd_en            (act_rd_en),
        .act_rd_addr          (act_rd_addr),
        .act_rd_data          (act_rd_data),
        .par_rd_en            (par_rd_en),
        .par_rd_addr          (par_rd_addr),
        .par_rd_data          (par_rd_data),
        .ln_data_num          (ln_data_num),
        .ln_data_num_vld      (ln_data_num_vld),
        .ln_in_scale_pos      (ln_in_scale_pos),
        .ln_in_scale_pos_vld  (ln_in_scale_pos_vld),
        .ln_out_scale_pos     (ln_out_scale_pos),
        .ln_out_scale_pos_vld (ln_out_scale_pos_vld),
        .ln_fixed_data        (ln_fixed_data),
        .ln_fixed_data_vld    (ln_fixed_data_vld),
        .ln_gamma             (ln_gamma),
        .ln_gamma_vld         (ln_gamma_vld),
        .ln_beta              (ln_beta),
        .ln_beta_vld          (ln_beta_vld),
        .ln_last              (ln_last),
        .busy                 (busy),
        .done                 (done)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: data appears one cycle after a read enable; on cycles
    // without a read the bus carries junk so misaligned capture shows up.
    always @(posedge clk) begin
        if (act_rd_en) act_rd_data <= act_mem[act_rd_addr];
        else           act_rd_data <= {$urandom, $urandom};
        if (par_rd_en) par_rd_data <= par_mem[par_rd_addr];
        else           par_rd_data <= {8{$urandom}};
    end

    function automatic logic [BUS*8-1:0] expAct(input logic [BUS*8-1:0] raw, input logic [BUS-1:0] m);
        logic [BUS*8-1:0] r;
        r = raw;
        for (int i = 0; i < BUS; i++) if (ZERO_EN && !m[i]) r[8*i +: 8] = '0;
        return r;
    endfunction

    function automatic logic [HALF-1:0] expPar(input logic [HALF-1:0] raw, input logic [BUS-1:0] m);
        logic [HALF-1:0] r;
        r = raw;
        for (int i = 0; i < BUS; i++) if (ZERO_EN && !m[i]) r[FPW*i +: FPW] = '0;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one vector launched at cycle T and checks every output for each
    // cycle up to one past the expected done pulse. lat is the layer-norm
    // delay: ln_last arrives lat cycles after the final data word.
    // stray launches a second start while the vector waits for ln_last.
    task automatic applyStimulus(input int dn, input int abase, input int pbase,
                                 input int isp, input int osp, input int lat, input bit stray);
        int w, rem, last_n, done_n, k;
        logic [BUS-1:0] m;
        w      = (dn + BUS - 1) / BUS;
        rem    = dn % BUS;
        last_n = w + 3 + lat;
        done_n = (dn == 0) ? 1 : last_n + 1;
        @(negedge clk);
        start             = 1'b1;
        cfg_data_num      = DNW'(dn);
        cfg_act_base      = AW'(abase);
        cfg_par_base      = AW'(pbase);
        cfg_in_scale_pos  = SPW'(isp);
        cfg_out_scale_pos = SPW'(osp);
        for (int n = 1; n <= done_n + 1; n++) begin
            @(negedge clk);
            start   = 1'b0;
            ln_last = 1'b0;
            checkOutput("busy", 256'(busy), 256'(n <= done_n));
            checkOutput("done", 256'(done), 256'(n == done_n));
            checkOutput("dn_vld", 256'(ln_data_num_vld), 256'(n == 1 && dn != 0));
            checkOutput("isp_vld", 256'(ln_in_scale_pos_vld), 256'(n == 1 && dn != 0));
            checkOutput("osp_vld", 256'(ln_out_scale_pos_vld), 256'(n == 1 && dn != 0));
            if (n == 1 && dn != 0) begin
                checkOutput("dn", 256'(ln_data_num), 256'(dn));
                checkOutput("isp", 256'($unsigned(ln_in_scale_pos)), 256'(isp & 31));
                checkOutput("osp", 256'($unsigned(ln_out_scale_pos)), 256'(osp & 31));
            end
            checkOutput("act_en", 256'(act_rd_en), 256'(dn != 0 && n >= 2 && n <= w + 1));
            checkOutput("par_en", 256'(par_rd_en), 256'(dn != 0 && n >= 2 && n <= w + 1));
            if (dn != 0 && n >= 2 && n <= w + 1) begin
                checkOutput("act_addr", 256'(act_rd_addr), 256'((abase + n - 2) & 255));
                checkOutput("par_addr", 256'(par_rd_addr), 256'((pbase + n - 2) & 255));
            end
            k = n - 4;
            m = '0;
            if (dn != 0 && k >= 0 && k < w) begin
                m = (k == w - 1 && rem != 0) ? BUS'((1 << rem) - 1) : '1;
            end
            checkOutput("data_vld", 256'(ln_fixed_data_vld), 256'(m));
            checkOutput("gamma_vld", 256'(ln_gamma_vld), 256'(m));
            checkOutput("beta_vld", 256'(ln_beta_vld), 256'(m));
            if (m != '0) begin
                checkOutput("data", 256'(ln_fixed_data), 256'(expAct(act_mem[(abase + k) & 255], m)));
                checkOutput("gamma", 256'(ln_gamma), 256'(expPar(par_mem[(pbase + k) & 255][HALF-1:0], m)));
                checkOutput("beta", 256'(ln_beta), 256'(expPar(par_mem[(pbase + k) & 255][2*HALF-1:HALF], m)));
            end
            if (dn != 0 && n == last_n) ln_last = 1'b1;
            if (stray && dn != 0 && n == w + 3) begin
                start        = 1'b1;
                cfg_data_num = DNW'(5);
                cfg_act_base = AW'(abase + 100);
            end
        end
        start   = 1'b0;
        ln_last = 1'b0;
    endtask

    // Directed scenarios first, then a batch of random vectors.
    initial begin
        for (int i = 0; i < 256; i++) begin
            act_mem[i] = {$urandom, $urandom};
            par_mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
        rst_n             = 1'b0;
        start             = 1'b0;
        ln_last           = 1'b0;
        cfg_data_num      = '0;
        cfg_act_base      = '0;
        cfg_par_base      = '0;
        cfg_in_scale_pos  = '0;
        cfg_out_scale_pos = '0;
        act_rd_data       = '0;
        par_rd_data       = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 256'(busy), 256'(0));
        checkOutput("rst_done", 256'(done), 256'(0));
        checkOutput("rst_act_en", 256'(act_rd_en), 256'(0));
        checkOutput("rst_data_vld", 256'(ln_fixed_data_vld), 256'(0));
        checkOutput("rst_dn", 256'(ln_data_num), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] two full words from 0x10");
        applyStimulus(16, 'h10, 'h40, 3, -2, 2, 1'b0);
        $display("[TB] partial tail word");
        applyStimulus(13, 'h20, 'h50, -5, 7, 1, 1'b0);
        $display("[TB] empty vector");
        applyStimulus(0, 'h30, 'h60, 1, 1, 1, 1'b0);
        $display("[TB] stray start while waiting for ln_last");
        applyStimulus(9, 'h33, 'h77, 4, 4, 3, 1'b1);
        $display("[TB] address wrap");
        applyStimulus(16, 'hFF, 'hFE, 0, 0, 1, 1'b0);

        $display("[TB] ln_last in idle");
        @(negedge clk);
        ln_last = 1'b1;
        @(negedge clk);
        ln_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("idle_done", 256'(done), 256'(0));
            checkOutput("idle_busy", 256'(busy), 256'(0));
            @(negedge clk);
        end

        $display("[TB] reset mid-stream");
        start        = 1'b1;
        cfg_data_num = DNW'(64);
        cfg_act_base = AW'('h80);
        cfg_par_base = AW'('h90);
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("pre_rst_vld", 256'(ln_fixed_data_vld), 256'(8'hFF));
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 256'(busy), 256'(0));
        checkOutput("mid_rst_vld", 256'(ln_fixed_data_vld), 256'(0));
        checkOutput("mid_rst_data", 256'(ln_fixed_data), 256'(0));
        checkOutput("mid_rst_act_en", 256'(act_rd_en), 256'(0));
        checkOutput("mid_rst_addr", 256'(act_rd_addr), 256'(0));
        checkOutput("mid_rst_dn", 256'(ln_data_num), 256'(0));
        checkOutput("mid_rst_gamma", 256'(ln_gamma), 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(64, 'h80, 'h90, 2, -3, 2, 1'b0);

        $display("[TB] random vectors");
        for (int t = 0; t < 12; t++) begin
            applyStimulus($urandom_range(0, 40), $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 3),
                          1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
